// File: rtl/alu_ctrl_multu.sv
// ALU control decode plus HI/LO register pair with a sequential 32-step unsigned shift-add multiplier.
// Latency: ALUCtl/HiLoOut combinational; MULTU result in HI/LO after 32 iterations, Done one cycle later.
// Backpressure: Stall holds MULTU/MFHI/MFLO while the multiplier iterates; other instructions flow.
module alu_ctrl_multu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic             Valid,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUCtl,
    output logic             HiLoSel,
    output logic [WIDTH-1:0] HiLoOut,
    output logic             Stall,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum;
    logic             is_rtype, is_multu, is_mfhi, is_mflo;

    always_comb begin
        ALUCtl = 3'b010;
        case (ALUOp)
            2'b00: ALUCtl = 3'b010;
            2'b01: ALUCtl = 3'b110;
            2'b11: ALUCtl = 3'b000;
            default: begin
                case (Funct)
                    6'b100000: ALUCtl = 3'b010;
                    6'b100010: ALUCtl = 3'b110;
                    6'b100100: ALUCtl = 3'b000;
                    6'b100101: ALUCtl = 3'b001;
                    6'b101010: ALUCtl = 3'b111;
                    6'b000000: ALUCtl = 3'b011;
                    default:   ALUCtl = 3'b010;
                endcase
            end
        endcase
    end

    assign is_rtype = Valid && (ALUOp == 2'b10);
    assign is_multu = is_rtype && (Funct == 6'b011001);
    assign is_mfhi  = is_rtype && (Funct == 6'b010000);
    assign is_mflo  = is_rtype && (Funct == 6'b010010);

    assign HiLoSel = is_mfhi | is_mflo;
    assign HiLoOut = is_mfhi ? hi : (is_mflo ? lo : '0);

    assign Busy  = (state == MUL);
    assign Done  = (state == DONE);
    assign Stall = Busy & (is_multu | is_mfhi | is_mflo);

    // Carry out of the upper-half add becomes the MSB after the right shift.
    assign sum = {1'b0, acc} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};

    always_comb begin
        state_nxt = state;
        case (state)
            MUL:     state_nxt = (cnt == CNT_LAST) ? DONE : MUL;
            default: state_nxt = is_multu ? MUL : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            acc    <= sum[WIDTH:1];
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
                hi <= sum[WIDTH:1];
                lo <= {sum[0], mplier[WIDTH-1:1]};
            end
        end else if (is_multu) begin
            mcand  <= SrcA;
            mplier <= SrcB;
            acc    <= '0;
            cnt    <= '0;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_multu.sv
// Self-checking bench for alu_ctrl_multu: decode table, multiply timing/results, stall, reset abort.
module tb_alu_ctrl_multu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;
    logic        Valid;
    logic [31:0] SrcA, SrcB;
    logic [2:0]  ALUCtl;
    logic        HiLoSel;
    logic [31:0] HiLoOut;
    logic        Stall, Busy, Done;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    alu_ctrl_multu #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .Funct(Funct), .Valid(Valid),
        .SrcA(SrcA), .SrcB(SrcB), .ALUCtl(ALUCtl), .HiLoSel(HiLoSel),
        .HiLoOut(HiLoOut), .Stall(Stall), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] funct;
        logic       valid;
        logic [2:0] exp_ctl;
        logic       exp_sel;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode taken straight from the operation table.
    function automatic logic [2:0] ref_ctl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 3'b010;
        if (op == 2'b01) return 3'b110;
        if (op == 2'b11) return 3'b000;
        if (f == 6'b100010) return 3'b110;
        if (f == 6'b100100) return 3'b000;
        if (f == 6'b100101) return 3'b001;
        if (f == 6'b101010) return 3'b111;
        if (f == 6'b000000) return 3'b011;
        return 3'b010;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [1:0] op, input logic [5:0] f);
        Valid = v;
        ALUOp = op;
        Funct = f;
    endtask

    // Issue MULTU in the current cycle; returns positioned in the Done cycle (cycle 33).
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        present(1'b1, 2'b10, F_MULTU);
        SrcA = a;
        SrcB = b;
        next_cycle();
        present(1'b0, 2'b00, 6'd0);
        for (int i = 1; i <= 32; i++) begin
            SrcA = $urandom;
            SrcB = $urandom;
            @(negedge clk);
            if (Busy) busy_cnt++;
            if (Done) done_cnt++;
            next_cycle();
        end
        chk("busy_cycles", 64'(busy_cnt), 64'd32);
        chk("done_early", 64'(done_cnt), 64'd0);
        @(negedge clk);
        chk("done_pulse", {63'd0, Done}, 64'd1);
        chk("busy_after", {63'd0, Busy}, 64'd0);
    endtask

    // MFLO in the current cycle, MFHI in the next one.
    task automatic read_check(input logic [63:0] prod);
        present(1'b1, 2'b10, F_MFLO);
        #1;
        chk("mflo_val", {32'd0, HiLoOut}, {32'd0, prod[31:0]});
        chk("mflo_sel", {63'd0, HiLoSel}, 64'd1);
        next_cycle();
        present(1'b1, 2'b10, F_MFHI);
        #1;
        chk("mfhi_val", {32'd0, HiLoOut}, {32'd0, prod[63:32]});
        chk("mfhi_stall", {63'd0, Stall}, 64'd0);
        next_cycle();
        present(1'b0, 2'b00, 6'd0);
    endtask

    initial begin
        logic [63:0] exp_prod;
        logic [31:0] ra, rb;
        int cnt;

        vecs[0]  = '{2'b00, 6'b111111, 1'b1, 3'b010, 1'b0};
        vecs[1]  = '{2'b01, 6'b000000, 1'b1, 3'b110, 1'b0};
        vecs[2]  = '{2'b11, 6'b100101, 1'b1, 3'b000, 1'b0};
        vecs[3]  = '{2'b10, 6'b100000, 1'b1, 3'b010, 1'b0};
        vecs[4]  = '{2'b10, 6'b100010, 1'b1, 3'b110, 1'b0};
        vecs[5]  = '{2'b10, 6'b100100, 1'b1, 3'b000, 1'b0};
        vecs[6]  = '{2'b10, 6'b100101, 1'b1, 3'b001, 1'b0};
        vecs[7]  = '{2'b10, 6'b101010, 1'b1, 3'b111, 1'b0};
        vecs[8]  = '{2'b10, 6'b000000, 1'b1, 3'b011, 1'b0};
        vecs[9]  = '{2'b10, 6'b111111, 1'b1, 3'b010, 1'b0};
        vecs[10] = '{2'b10, F_MFHI,    1'b1, 3'b010, 1'b1};
        vecs[11] = '{2'b10, F_MFLO,    1'b0, 3'b010, 1'b0};

        rst_n = 1'b0;
        present(1'b1, 2'b10, F_MFHI);
        SrcA = 32'd0;
        SrcB = 32'd0;
        #12;
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_done", {63'd0, Done}, 64'd0);
        chk("rst_stall", {63'd0, Stall}, 64'd0);
        chk("rst_hilo", {32'd0, HiLoOut}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            present(vecs[i].valid, vecs[i].aluop, vecs[i].funct);
            #1;
            chk($sformatf("tbl_ctl%0d", i), {61'd0, ALUCtl}, {61'd0, vecs[i].exp_ctl});
            chk($sformatf("tbl_sel%0d", i), {63'd0, HiLoSel}, {63'd0, vecs[i].exp_sel});
        end
        present(1'b0, 2'b00, 6'd0);
        next_cycle();

        // Directed multiplies.
        start_and_wait(32'd3, 32'd5);
        read_check(64'd15);
        start_and_wait(32'hFFFFFFFF, 32'hFFFFFFFF);
        read_check(64'hFFFFFFFE_00000001);

        // MFHI stalled from cycle 5, ADD slips through at cycle 6.
        ra = 32'hDEADBEEF;
        rb = 32'h12345678;
        exp_prod = 64'(ra) * 64'(rb);
        present(1'b1, 2'b10, F_MULTU);
        SrcA = ra;
        SrcB = rb;
        next_cycle();
        present(1'b0, 2'b00, 6'd0);
        for (int i = 1; i <= 4; i++) next_cycle();
        cnt = 0;
        for (int c = 5; c <= 32; c++) begin
            if (c == 6) begin
                present(1'b1, 2'b00, 6'd0);
                #1;
                chk("add_stall", {63'd0, Stall}, 64'd0);
                chk("add_ctl", {61'd0, ALUCtl}, 64'd2);
            end else begin
                present(1'b1, 2'b10, F_MFHI);
                @(negedge clk);
                if (Stall) cnt++;
            end
            next_cycle();
        end
        chk("mfhi_stall_cycles", 64'(cnt), 64'd27);
        present(1'b1, 2'b10, F_MFHI);
        #1;
        chk("mfhi_done_stall", {63'd0, Stall}, 64'd0);
        chk("mfhi_done_dn", {63'd0, Done}, 64'd1);
        chk("mfhi_done_val", {32'd0, HiLoOut}, {32'd0, exp_prod[63:32]});
        next_cycle();
        present(1'b0, 2'b00, 6'd0);

        // Reset abort mid-multiply.
        start_and_wait(32'h2468ACF0, 32'h80000000);
        read_check(64'h12345678_00000000);
        present(1'b1, 2'b10, F_MULTU);
        SrcA = 32'h10000;
        SrcB = 32'h10000;
        next_cycle();
        present(1'b0, 2'b00, 6'd0);
        for (int i = 1; i <= 9; i++) next_cycle();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        chk("abort_done", {63'd0, Done}, 64'd0);
        present(1'b1, 2'b10, F_MFHI);
        #1;
        chk("abort_hi", {32'd0, HiLoOut}, 64'd0);
        present(1'b1, 2'b10, F_MFLO);
        #1;
        chk("abort_lo", {32'd0, HiLoOut}, 64'd0);
        present(1'b0, 2'b00, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done || Busy) cnt++;
        end
        chk("abort_quiet", 64'(cnt), 64'd0);
        next_cycle();
        start_and_wait(32'd7, 32'd6);
        read_check(64'd42);

        // Back-to-back: second MULTU issued in the Done cycle.
        start_and_wait(32'h89ABCDEF, 32'h00C0FFEE);
        start_and_wait(32'd0, 32'hFFFFFFFF);
        read_check(64'd0);

        // Randomised multiplies against plain 64-bit arithmetic.
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k == 0) ? 32'hFFFFFFFF : $urandom;
            exp_prod = 64'(ra) * 64'(rb);
            start_and_wait(ra, rb);
            read_check(exp_prod);
        end

        // Randomised decode while idle.
        for (int k = 0; k < 200; k++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic       v;
            logic       sel;
            op = 2'($urandom_range(0, 3));
            f  = (k % 3 == 0) ? 6'($urandom_range(0, 63)) : vecs[k % 12].funct;
            v  = 1'($urandom_range(0, 1));
            sel = v && (op == 2'b10) && (f == F_MFHI || f == F_MFLO);
            present(v, op, f);
            #1;
            chk("rnd_ctl", {61'd0, ALUCtl}, {61'd0, ref_ctl(op, f)});
            chk("rnd_sel", {63'd0, HiLoSel}, {63'd0, sel});
            #1;
        end
        present(1'b0, 2'b00, 6'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_ctrl_multu.md
Name: alu_ctrl_multu

Overview:
- Receiving end of the main control unit's 2-bit ALUOp interface.
- Combines ALUOp with the R-type funct field and drives the 3-bit ALU operation select.
- Owns the HI/LO register pair, with a sequential 32-cycle unsigned shift-add multiplier for MULTU and read-out for MFHI/MFLO.
- Sits between the control unit/decode and the ALU/writeback mux; asserts Stall to hold issue while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ALUOp  input  2  from control unit: 00 add, 01 sub, 10 R-type (use Funct), 11 and (ANDI).
- Funct  input  6  instruction funct field [5:0].
- Valid  input  1  instruction present in this cycle.
- SrcA  input  WIDTH  rs operand (multiplicand).
- SrcB  input  WIDTH  rt operand (multiplier).
- ALUCtl  output  3  ALU operation select.
- HiLoSel  output  1  1 when the writeback value must come from HiLoOut, not the ALU.
- HiLoOut  output  WIDTH  HI for MFHI, LO for MFLO, else 0.
- Stall  output  1  hold the instruction and PC this cycle.
- Busy  output  1  multiplier iterating.
- Done  output  1  one-cycle pulse when HI/LO receive a new product.

Behaviour:
- Reset (async, rst_n=0): state IDLE, HI=0, LO=0, accumulator/multiplicand/multiplier regs=0, counter=0.
  - Outputs during reset: Busy=0, Done=0, Stall=0, HiLoOut=0.
- ALUCtl (combinational, independent of state):
  - ALUOp 00 -> 010 (add); ALUOp 01 -> 110 (sub); ALUOp 11 -> 000 (and).
  - ALUOp 10 by Funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, 000000 -> 011 (sll).
  - ALUOp 10 with any other Funct, including 011001/010000/010010 -> 010.
- Decoded strobes (require Valid=1 and ALUOp=10):
  - isMULTU: Funct=011001.
  - isMFHI: Funct=010000.
  - isMFLO: Funct=010010.
- HiLoSel = isMFHI | isMFLO.
- HiLoOut = HI if isMFHI, LO if isMFLO, else 0. Reads are combinational from the registers.
- State machine (IDLE, MUL, DONE):
  - IDLE or DONE, isMULTU at edge: latch mcand=SrcA, mplier=SrcB, acc=0, counter=0; go to MUL.
  - IDLE or DONE, no MULTU: go to / stay in IDLE. DONE always lasts exactly one cycle.
  - MUL, each edge: if mplier[0], the upper half of acc += mcand, carry kept in a WIDTH+1 bit add. Then shift {carry, acc_hi, mplier} right by 1 and increment counter.
  - MUL, edge with counter == 2**CNT_W-1: perform the final iteration, write {HI,LO} = 2*WIDTH-bit product, go to DONE.
- Latency: MULTU accepted at edge 0; Busy high cycles 1..32; HI/LO valid after edge 32; Done high in cycle 33.
- Busy = (state==MUL). Done = (state==DONE).
- Stall = Busy & (isMULTU | isMFHI | isMFLO).
  - Other instructions proceed while Busy, with Stall=0.
  - A stalled MULTU/MFHI/MFLO is re-presented by upstream and accepted in the DONE or IDLE cycle.
- MFHI/MFLO in the DONE cycle return the new product; back-to-back MULTU accepted in DONE.
- Operand changes on SrcA/SrcB while Busy are ignored, since operands are latched.
- Reset mid-MUL: immediate abort, HI/LO cleared to 0, no Done pulse.
- Product is unsigned 2*WIDTH bits; no overflow possible.

Test Plan:
- ALUOp/Funct sweep: 00 -> 010; 01 -> 110; 11 -> 000; 10 with Funct 100100/100101/101010/000000/111111 -> 000/001/111/011/010.
- MULTU SrcA=3, SrcB=5 -> Busy for 32 cycles, Done in cycle 33; then MFLO gives HiLoOut=0x0000000F, HiLoSel=1; MFHI gives 0.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- MFHI presented at cycle 5 of a multiply -> Stall=1 through cycle 32, Stall=0 in cycle 33, HiLoOut = new HI. An ADD issued at cycle 6 -> Stall=0, ALUCtl=010.
- Prior HI=0x12345678; MULTU 0x10000 x 0x10000; rst_n pulled low at cycle 10 -> Busy=0 immediately, HI=LO=0, no Done pulse. A fresh MULTU 7x6 after release -> LO=42.
- MULTU 0 x 0xFFFFFFFF re-issued in the DONE cycle of a prior multiply -> accepted with no idle gap, result HI=LO=0.
